wb_regfile: RTL
===============

# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register for the 5-stage MIPS core. It selects the writeback destination and data from the WB-stage control and data fields, gates conditional moves, and owns the 32×32 general-purpose register file. Two combinational read ports feed the decode stage, with same-cycle write bypass. It also exports the resolved write for the forwarding unit and counts retired instructions.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- NREGS, 32, register count; index width is 5

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Instruction_WB  in  32  instruction in WB; 0 = bubble
- ALUResult_WB  in  32  ALU result
- ReadDataFromMem_WB  in  32  load data
- ReadData1_WB  in  32  rs value carried for conditional moves
- MemtoReg_WB  in  1  1 = write load data
- RegWrite_WB  in  1  write request
- RegWriteSel_WB  in  1  1 = conditional move (write ReadData1_WB)
- Zero_WB  in  1  move condition true (EX-computed)
- RegDst_WB  in  2  destination select
- ReadReg1, ReadReg2  in  5  decode read addresses
- ReadData1, ReadData2  out  32  read data
- WriteEn_Fwd  out  1  resolved write enable
- WriteReg_Fwd  out  5  resolved destination
- WriteData_Fwd  out  32  resolved write data
- RetireCount  out  32  retired non-bubble instructions

## Operation
- Destination (combinational): RegDst_WB 00 → Instruction_WB[20:16] (rt); 01 → [15:11] (rd); 10 → 5'd31 (link); 11 → reserved, write suppressed.
- Data select: RegWriteSel_WB=1 → ReadData1_WB; else MemtoReg_WB=1 → ReadDataFromMem_WB; else ALUResult_WB. RegWriteSel_WB has priority over MemtoReg_WB.
- Write enable: RegWrite_WB AND RegDst_WB≠11 AND destination≠0 AND (RegWriteSel_WB=0 OR Zero_WB=1).
- The _Fwd outputs carry the resolved enable, destination and data every cycle. They are combinational.
- Register file: 32 entries. Register 0 is never written and always reads 0. The write commits on rising Clk when the write enable is 1.
- Read ports: combinational. If ReadRegN equals the destination and the write enable is 1 in the same cycle, ReadDataN returns the write data (write-first bypass). Address 0 always returns 0.
- RetireCount increments by 1 on each rising Clk where Instruction_WB≠0. Squashed moves (condition false) still count. The counter wraps from 0xFFFFFFFF to 0.

## Timing
- Reset asserted: all registers and RetireCount go to 0 immediately, with no clock needed. ReadData1/2 read 0. The _Fwd outputs follow their inputs combinationally.
- While Reset is high, no write commits and the counter holds at 0. The first commit can occur on the first rising Clk after Reset deasserts.
- Write latency: data is visible at the read ports in the same cycle through the bypass, and from storage on the cycle after the edge.
- Reset asserted mid-stream discards the in-flight write for that cycle.
- Simultaneous reads of the same address on both ports are permitted and return identical data.

## Structure
- A shared package holds: the RegDst encodings (RD_RT=2'b00, RD_RD=2'b01, RD_RA=2'b10); the link register index 31; and the bubble instruction value 0.
- One sub-module, wb_gpr_array, is natural. It contains the storage, reset, the $0 rule and the bypassed read ports. Destination/data select, the forwarding outputs and the counter live in the top level.

## Test plan
- Reset, then read all 32 registers on both ports → every ReadData = 0 and RetireCount = 0.
- R-type: RegWrite=1, RegDst=01, Instruction rd=5, ALUResult=0x1234_5678, ReadReg1=5 in the same cycle → bypass gives 0x12345678 before the edge, and storage holds it after the edge; RetireCount = 1.
- Load to rt=8, MemtoReg=1, mem=0xDEAD_BEEF, ALU=0x0 → r8 = 0xDEADBEEF. Same stimulus with rt=0 → WriteEn_Fwd=0 and r0 reads 0.
- Conditional move to rd=3, ReadData1_WB=0xA5A5: with Zero=0, r3 is unchanged and the count still increments; with Zero=1, r3 = 0xA5A5 even with MemtoReg=1.
- JAL: RegDst=10, ALUResult=0x0040_0008 → r31 = 0x00400008. RegDst=11 → no write.
- Preload RetireCount to 0xFFFFFFFF via 2^32−1 non-bubble cycles (or a forced value), then one more → it wraps to 0. Assert Reset mid-write → no commit and all state is 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared encodings for the MIPS writeback stage: RegDst selects, link register
// index and the bubble instruction, plus the destination decode used by the top.
package wb_regfile_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;
  localparam logic [1:0] RD_RSVD = 2'b11;

  localparam logic [REG_AW-1:0] LINK_REG     = 5'd31;
  localparam logic [31:0]       BUBBLE_INSTR = 32'h0000_0000;

  // The reserved RegDst code maps to $0, which the write-enable logic suppresses anyway.
  function automatic logic [REG_AW-1:0] selDest(input logic [1:0] regDst,
                                                input logic [31:0] instr);
    logic [REG_AW-1:0] dest;
    dest = '0;
    case (regDst)
      RD_RT:   dest = instr[20:16];
      RD_RD:   dest = instr[15:11];
      RD_RA:   dest = LINK_REG;
      default: dest = '0;
    endcase
    return dest;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register / decode stage and the writeback register file.
// No valid/ready: every cycle carries exactly one WB slot, and Instruction_WB == 0 marks a bubble.
interface wb_regfile_if #(parameter int DATA_W = 32);
  import wb_regfile_pkg::*;

  logic [31:0]        Instruction_WB;
  logic [DATA_W-1:0]  ALUResult_WB;
  logic [DATA_W-1:0]  ReadDataFromMem_WB;
  logic [DATA_W-1:0]  ReadData1_WB;
  logic               MemtoReg_WB;
  logic               RegWrite_WB;
  logic               RegWriteSel_WB;
  logic               Zero_WB;
  logic [1:0]         RegDst_WB;
  logic [REG_AW-1:0]  ReadReg1;
  logic [REG_AW-1:0]  ReadReg2;
  logic [DATA_W-1:0]  ReadData1;
  logic [DATA_W-1:0]  ReadData2;
  logic               WriteEn_Fwd;
  logic [REG_AW-1:0]  WriteReg_Fwd;
  logic [DATA_W-1:0]  WriteData_Fwd;
  logic [31:0]        RetireCount;

  modport master (
    output Instruction_WB, ALUResult_WB, ReadDataFromMem_WB, ReadData1_WB,
           MemtoReg_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RegDst_WB,
           ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteEn_Fwd, WriteReg_Fwd, WriteData_Fwd, RetireCount
  );

  modport slave (
    input  Instruction_WB, ALUResult_WB, ReadDataFromMem_WB, ReadData1_WB,
           MemtoReg_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB, RegDst_WB,
           ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteEn_Fwd, WriteReg_Fwd, WriteData_Fwd, RetireCount
  );

endinterface

// File: rtl/wb_gpr_array.sv
// 32x32 general-purpose register storage with two write-first bypassed read ports.
// $0 is hardwired to zero on both the write and read side.
module wb_gpr_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [REG_AW-1:0] ReadReg1,
  input  logic [REG_AW-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WriteEn && (WriteReg != '0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Bypass is held off during reset so both ports read the cleared storage.
  function automatic logic [DATA_W-1:0] readPort(input logic [REG_AW-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (addr == '0)
      data = '0;
    else if (!Reset && WriteEn && (WriteReg == addr))
      data = WriteData;
    else
      data = regs[addr];
    return data;
  endfunction

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    ReadData1 = readPort(ReadReg1);
    ReadData2 = readPort(ReadReg2);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: resolves destination/data/enable from the MEM/WB fields, owns the
// register file, exports the resolved write for forwarding and counts retired instructions.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  wb_regfile_if.slave bus
);

  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              writeEn;
  logic [31:0]       retireCount;

  always_comb begin
    writeReg  = '0;
    writeData = '0;
    writeEn   = 1'b0;
    writeReg  = selDest(bus.RegDst_WB, bus.Instruction_WB);
    // Conditional move outranks load data.
    if (bus.RegWriteSel_WB)
      writeData = bus.ReadData1_WB;
    else if (bus.MemtoReg_WB)
      writeData = bus.ReadDataFromMem_WB;
    else
      writeData = bus.ALUResult_WB;
    writeEn = bus.RegWrite_WB && (bus.RegDst_WB != RD_RSVD) && (writeReg != '0) &&
              (!bus.RegWriteSel_WB || bus.Zero_WB);
  end

  assign bus.WriteEn_Fwd   = writeEn;
  assign bus.WriteReg_Fwd  = writeReg;
  assign bus.WriteData_Fwd = writeData;

  wb_gpr_array #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_gpr (
    .Clk       (Clk),
    .Reset     (Reset),
    .WriteEn   (writeEn),
    .WriteReg  (writeReg),
    .WriteData (writeData),
    .ReadReg1  (bus.ReadReg1),
    .ReadReg2  (bus.ReadReg2),
    .ReadData1 (bus.ReadData1),
    .ReadData2 (bus.ReadData2)
  );

  // Squashed conditional moves are still retired instructions, so only bubbles are skipped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      retireCount <= '0;
    else if (bus.Instruction_WB != BUBBLE_INSTR)
      retireCount <= retireCount + 32'd1;
  end

  assign bus.RetireCount = retireCount;

endmodule
